// File: rtl/i2c_rd_master.sv
// I2C master reader: START, address byte with the read bit, qty data bytes ACKed
// except the last (NACKed), then STOP and a short bus-free hold before returning idle.
module i2c_rd_master #(
  parameter int FCLK  = 10000,
  parameter int SPEED = 400
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         ioScl,
  inout  wire         ioSda,
  input  logic [6:0]  iDevID,
  input  logic        iStart,
  input  logic [10:0] iByteQnty,
  output logic [7:0]  oByteOut,
  output logic        oByteValid,
  output logic [10:0] oByteCnt,
  output logic        oAckErr,
  output logic        oAction
);

  localparam int Q  = FCLK / (4 * SPEED);
  localparam int QW = (Q > 2) ? $clog2(Q) : 1;
  localparam logic [QW-1:0] QLAST = QW'(Q - 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, AACK, READ, MACK, STOP, HOLD} stateT;

  stateT       state, stateNext;
  logic [QW-1:0] qCnt;
  logic [1:0]  phase;
  logic [2:0]  bitCnt;
  logic [7:0]  shiftReg;
  logic [10:0] qty;
  logic        sdaLow, rxBit, byteDone;
  logic        sclIn, sdaIn, inBit, stretchHold, qTick, sampleNow, segEnd, sclLow;

  assign sclIn   = ioScl;
  assign sdaIn   = ioSda;
  assign ioScl   = sclLow ? 1'b0 : 1'bz;
  assign ioSda   = sdaLow ? 1'b0 : 1'bz;
  assign oAction = (state != IDLE);

  // A slave stretching SCL freezes the third quarter of a bit until SCL reads high.
  always_comb begin
    inBit       = (state == ADDR) || (state == AACK) || (state == READ) || (state == MACK);
    stretchHold = inBit && (phase == 2'd2) && !sclIn;
    qTick       = (qCnt == QLAST) && !stretchHold;
    sampleNow   = inBit && (phase == 2'd2) && qTick;
    segEnd      = 1'b0;
    sclLow      = 1'b0;
    stateNext   = state;
    case (state)
      IDLE:  if (iStart && sclIn && sdaIn) stateNext = START;
      START: begin
        segEnd = (phase == 2'd1) && qTick;
        if (segEnd) stateNext = ADDR;
      end
      ADDR: begin
        sclLow = !phase[1];
        segEnd = (phase == 2'd3) && qTick;
        if (segEnd && bitCnt == 3'd7) stateNext = AACK;
      end
      AACK: begin
        sclLow = !phase[1];
        segEnd = (phase == 2'd3) && qTick;
        if (segEnd) stateNext = (rxBit || qty == 11'd0) ? STOP : READ;
      end
      READ: begin
        sclLow = !phase[1];
        segEnd = (phase == 2'd3) && qTick;
        if (segEnd && bitCnt == 3'd7) stateNext = MACK;
      end
      MACK: begin
        sclLow = !phase[1];
        segEnd = (phase == 2'd3) && qTick;
        if (segEnd) stateNext = (oByteCnt == qty) ? STOP : READ;
      end
      STOP: begin
        sclLow = (phase == 2'd0);
        segEnd = (phase == 2'd1) && qTick;
        if (segEnd) stateNext = HOLD;
      end
      HOLD: begin
        segEnd = (phase == 2'd1) && qTick;
        if (segEnd) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      qCnt       <= '0;
      phase      <= 2'd0;
      bitCnt     <= 3'd0;
      shiftReg   <= 8'd0;
      qty        <= 11'd0;
      sdaLow     <= 1'b0;
      rxBit      <= 1'b0;
      byteDone   <= 1'b0;
      oByteOut   <= 8'd0;
      oByteValid <= 1'b0;
      oByteCnt   <= 11'd0;
      oAckErr    <= 1'b0;
    end else begin
      state      <= stateNext;
      oByteValid <= 1'b0;
      if (state == IDLE || segEnd) begin
        qCnt  <= '0;
        phase <= 2'd0;
      end else if (!stretchHold) begin
        if (qTick) begin
          qCnt  <= '0;
          phase <= phase + 2'd1;
        end else begin
          qCnt <= qCnt + QW'(1);
        end
      end
      // SDA is only ever updated on a segment boundary, i.e. at q0 entry of the next bit.
      case (state)
        IDLE: if (stateNext == START) begin
          qty      <= iByteQnty;
          shiftReg <= {iDevID, 1'b1};
          oByteCnt <= 11'd0;
          oAckErr  <= 1'b0;
          sdaLow   <= 1'b1;
        end
        START: if (segEnd) begin
          sdaLow   <= !shiftReg[7];
          shiftReg <= {shiftReg[6:0], 1'b0};
          bitCnt   <= 3'd0;
        end
        ADDR: if (segEnd) begin
          bitCnt <= bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            sdaLow <= 1'b0;
          end else begin
            sdaLow   <= !shiftReg[7];
            shiftReg <= {shiftReg[6:0], 1'b0};
          end
        end
        AACK: begin
          if (sampleNow) rxBit <= sdaIn;
          if (segEnd) begin
            bitCnt <= 3'd0;
            sdaLow <= (stateNext == STOP);
            if (rxBit) oAckErr <= 1'b1;
          end
        end
        READ: begin
          if (sampleNow) begin
            shiftReg <= {shiftReg[6:0], sdaIn};
            if (bitCnt == 3'd7) byteDone <= 1'b1;
          end
          if (segEnd) begin
            bitCnt <= bitCnt + 3'd1;
            sdaLow <= (bitCnt == 3'd7) && (oByteCnt < qty);
          end
        end
        MACK: if (segEnd) begin
          bitCnt <= 3'd0;
          sdaLow <= (stateNext == STOP);
        end
        STOP: if (segEnd) sdaLow <= 1'b0;
        default: ;
      endcase
      if (byteDone) begin
        byteDone   <= 1'b0;
        oByteOut   <= shiftReg;
        oByteValid <= 1'b1;
        oByteCnt   <= oByteCnt + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_rd_master.sv
// Bench for i2c_rd_master: open-drain slave model on the bus, scoreboard of expected
// bytes drained by a monitor, plus end-of-transfer checks against a transaction model.
module tb_i2c_rd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  iDevID = 7'd0;
  logic        iStart = 1'b0;
  logic [10:0] iByteQnty = 11'd0;
  logic [7:0]  oByteOut;
  logic        oByteValid;
  logic [10:0] oByteCnt;
  logic        oAckErr, oAction;
  wire         scl, sda;

  logic bfmSdaLow = 1'b0, bfmSclLow = 1'b0, holdSda = 1'b0;
  int   checks = 0, errors = 0;

  logic [7:0] dataQ[$], expByteQ[$];
  int         expCntQ[$];
  logic       mackBits[$], expMack[$];
  logic [7:0] rxAddr, expAddr, curByte;
  int         frame = 0, bitPos = 0, rises = 0, stops = 0, cyc = 0;
  int         stretchFrame = -1, stretchLeft = 0, stretchStart = 0, stretchSpan = 0;
  int         expRises = 0, expDelivered = 0, expAckErr = 0;
  logic       addrAck = 1'b1, bfmActive = 1'b0;

  pullup (scl);
  pullup (sda);
  assign scl = (bfmSclLow && !rst) ? 1'b0 : 1'bz;
  assign sda = ((bfmSdaLow && !rst) || holdSda) ? 1'b0 : 1'bz;

  i2c_rd_master #(.FCLK(10000), .SPEED(400)) dut (
    .clk(clk), .rst(rst), .ioScl(scl), .ioSda(sda), .iDevID(iDevID), .iStart(iStart),
    .iByteQnty(iByteQnty), .oByteOut(oByteOut), .oByteValid(oByteValid),
    .oByteCnt(oByteCnt), .oAckErr(oAckErr), .oAction(oAction)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Slave model: detects START/STOP, shifts in the address, ACKs or NACKs it,
  // presents data bits after each SCL fall and logs the master's ACK bits.
  initial begin
    logic sclP, sdaP, sNow, dNow, more;
    sclP = 1'b1;
    sdaP = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      sNow = scl;
      dNow = sda;
      if (rst) begin
        bfmActive = 1'b0; bfmSdaLow = 1'b0; bfmSclLow = 1'b0; stretchLeft = 0;
      end else begin
        if (stretchLeft > 0) begin
          stretchLeft--;
          if (stretchLeft == 0) bfmSclLow = 1'b0;
        end
        if (sclP && sNow && sdaP && !dNow) begin
          bfmActive = 1'b1; frame = 0; bitPos = 0; rxAddr = 8'd0;
          rises = 0; stops = 0; mackBits.delete(); bfmSdaLow = 1'b0;
        end else if (sclP && sNow && !sdaP && dNow) begin
          bfmActive = 1'b0; stops++; bfmSdaLow = 1'b0;
        end else if (bfmActive) begin
          if (!sclP && sNow) begin
            rises++;
            if (frame == 0 && bitPos < 8) rxAddr = {rxAddr[6:0], dNow};
            if (frame > 0 && bitPos == 8) mackBits.push_back(dNow);
            bitPos++;
          end else if (sclP && !sNow) begin
            if (frame == stretchFrame && bitPos == 3) begin
              bfmSclLow = 1'b1; stretchLeft = 62; stretchStart = cyc;
            end
            if (frame == stretchFrame && bitPos == 4) stretchSpan = cyc - stretchStart;
            if (bitPos == 8) begin
              bfmSdaLow = (frame == 0) ? addrAck : 1'b0;
            end else if (bitPos == 9) begin
              more = (frame == 0) ? addrAck : !mackBits[$];
              frame++;
              bitPos = 0;
              if (more && dataQ.size() > 0) begin
                curByte = dataQ.pop_front();
                bfmSdaLow = !curByte[7];
              end else begin
                bfmSdaLow = 1'b0;
              end
            end else if (frame > 0 && bitPos >= 1 && bitPos <= 7) begin
              bfmSdaLow = !curByte[7 - bitPos];
            end else begin
              bfmSdaLow = 1'b0;
            end
          end
        end
      end
      sclP = sNow;
      sdaP = dNow;
    end
  end

  // Monitor: every byte strobe must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst && oByteValid) begin
      if (expByteQ.size() == 0) chk("spurious byteValid", oByteValid, 0);
      else begin
        chk("byte value", oByteOut, expByteQ.pop_front());
        chk("byte count", oByteCnt, expCntQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [6:0] dev, input int qty, input bit ack,
                               input int stretch, input bit holdBus, input bit fixedData);
    logic [7:0] b;
    int n;
    expAddr      = {dev, 1'b1};
    addrAck      = ack;
    stretchFrame = stretch;
    stretchSpan  = 0;
    dataQ.delete();
    expMack.delete();
    expAckErr    = ack ? 0 : 1;
    expDelivered = ack ? qty : 0;
    expRises     = ack ? 9 * (qty + 1) + 1 : 10;
    if (ack) begin
      for (int i = 0; i < qty; i++) begin
        b = fixedData ? ((i % 2 == 0) ? 8'hA5 : 8'h5A) : 8'($urandom);
        dataQ.push_back(b);
        expByteQ.push_back(b);
        expCntQ.push_back(i + 1);
        expMack.push_back(i == qty - 1);
      end
    end
    @(negedge clk);
    iDevID = dev;
    iByteQnty = 11'(qty);
    iStart = 1'b1;
    if (holdBus) begin
      holdSda = 1'b1;
      n = 0;
      repeat (30) begin
        @(negedge clk);
        if (oAction) n++;
      end
      chk("idle while SDA busy", n, 0);
      holdSda = 1'b0;
      @(posedge clk);
      #1;
      chk("start on SDA release", oAction, 1);
    end else begin
      n = 0;
      while (!oAction && n < 5) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("accept", oAction, 1);
    end
    chk("byteCnt cleared at start", oByteCnt, 0);
    chk("ackErr cleared at start", oAckErr, 0);
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic checkOutput(input int qty);
    int n = 0;
    int budget = (qty + 1) * 9 * 24 + 400;
    int mackOk;
    while (oAction && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("transfer finished", oAction, 0);
    repeat (2) @(negedge clk);
    chk("bytes outstanding", expByteQ.size(), 0);
    chk("final byteCnt", oByteCnt, expDelivered);
    chk("final ackErr", oAckErr, expAckErr);
    chk("wire address", rxAddr, expAddr);
    chk("SCL rises", rises, expRises);
    chk("STOP seen", stops, 1);
    mackOk = (mackBits.size() == expMack.size());
    if (mackOk) foreach (expMack[i]) if (mackBits[i] !== expMack[i]) mackOk = 0;
    chk("master ACK/NACK pattern", mackOk, 1);
    chk("SCL released", scl, 1);
    chk("SDA released", sda, 1);
    expByteQ.delete();
    expCntQ.delete();
  endtask

  initial begin
    int n;
    $display("[TB] i2c_rd_master bench start");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    chk("reset byteOut", oByteOut, 0);
    chk("reset byteValid", oByteValid, 0);
    chk("reset byteCnt", oByteCnt, 0);
    chk("reset ackErr", oAckErr, 0);
    chk("reset action", oAction, 0);
    chk("reset SCL", scl, 1);
    chk("reset SDA", sda, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    applyStimulus(7'h3C, 2, 1'b1, -1, 1'b0, 1'b1);
    checkOutput(2);

    applyStimulus(7'h50, 2, 1'b0, -1, 1'b0, 1'b0);
    checkOutput(2);
    repeat (20) @(negedge clk);
    chk("ackErr held", oAckErr, 1);

    applyStimulus(7'h11, 0, 1'b1, -1, 1'b0, 1'b0);
    checkOutput(0);

    applyStimulus(7'h48, 1, 1'b1, 1, 1'b0, 1'b0);
    checkOutput(3);
    chk("stretched bit span >= 74", (stretchSpan >= 74) ? 1 : 0, 1);

    applyStimulus(7'h2A, 2, 1'b1, -1, 1'b0, 1'b0);
    n = 0;
    while (!(frame == 1 && bitPos >= 4) && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk("reached mid byte1", (frame == 1 && bitPos >= 4) ? 1 : 0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst SCL released", scl, 1);
    chk("rst SDA released", sda, 1);
    chk("rst action", oAction, 0);
    chk("rst byteCnt", oByteCnt, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    expByteQ.delete();
    expCntQ.delete();
    repeat (10) @(negedge clk);
    applyStimulus(7'h2A, 1, 1'b1, -1, 1'b0, 1'b0);
    checkOutput(1);

    applyStimulus(7'h61, 1, 1'b1, -1, 1'b1, 1'b0);
    checkOutput(1);

    for (int t = 0; t < 5; t++) begin
      logic [6:0] dev;
      int qty;
      bit ack;
      dev = 7'($urandom_range(0, 127));
      qty = $urandom_range(1, 4);
      ack = ($urandom_range(0, 3) != 0);
      applyStimulus(dev, qty, ack, -1, 1'b0, 1'b0);
      checkOutput(qty);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
